// File: rtl/video_rx_pkg.sv
// Shared types for the pixel receive path:
// FSM states and the elastic-buffer entry layout.
package video_rx_pkg;

    // Field widths of a buffered entry; the top-level width
    // parameters must not exceed these.
    localparam int cColorDepth = 16;
    localparam int cCoordWidth = 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DROP
    } rxState_t;

    typedef struct packed {
        logic [cColorDepth-1:0] pixel;
        logic [cCoordWidth-1:0] hpos;
        logic [cCoordWidth-1:0] vpos;
        logic                   sof;
        logic                   eol;
    } fifoEntry_t;

endpackage

// File: rtl/video_pixel_rx_fifo.sv
// Elastic buffer with a registered head entry.
// An empty buffer forwards a push straight into the head register.
module video_pixel_rx_fifo
    import video_rx_pkg::*;
#(
    parameter int pDepth = 16
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iPush,
    input  fifoEntry_t iData,
    input  logic       iPop,
    output fifoEntry_t oData,
    output logic       oFull,
    output logic       oEmpty
);

    localparam int cPtrW = $clog2(pDepth);

    fifoEntry_t       mem [pDepth];
    logic [cPtrW-1:0] wrPtr;
    logic [cPtrW-1:0] rdPtr;
    logic [cPtrW:0]   memCnt;
    logic             headVd;
    logic             load;
    logic             fromMem;
    logic             memWr;
    logic             memRd;

    assign load    = !headVd || iPop;
    assign fromMem = memCnt != '0;
    assign memRd   = load && fromMem;
    assign memWr   = iPush && !(load && !fromMem);
    assign oEmpty  = !headVd;
    assign oFull   = (memCnt + (cPtrW+1)'(headVd))
                     == (cPtrW+1)'(pDepth);

    // Storage array, written behind the head register.
    always_ff @(posedge iClk) begin
        if (memWr) begin
            mem[wrPtr] <= iData;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            memCnt <= '0;
        end else begin
            if (memWr) begin
                wrPtr <= wrPtr + cPtrW'(1);
            end
            if (memRd) begin
                rdPtr <= rdPtr + cPtrW'(1);
            end
            memCnt <= memCnt + (cPtrW+1)'(memWr)
                      - (cPtrW+1)'(memRd);
        end
    end

    // Head register refills whenever it is empty or being popped.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oData  <= '0;
            headVd <= 1'b0;
        end else if (load) begin
            headVd <= fromMem || iPush;
            if (fromMem) begin
                oData <= mem[rdPtr];
            end else if (iPush) begin
                oData <= iData;
            end
        end
    end

endmodule

// File: rtl/video_pixel_rx.sv
// Pixel receiver: raster tracking, elastic buffering,
// overflow handling and per-frame checksum.
module video_pixel_rx
    import video_rx_pkg::*;
#(
    parameter int pHdisplayWidth = 11,
    parameter int pVdisplayWidth = 11,
    parameter int pColorDepth    = 16,
    parameter int pFifoDepth     = 16
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iCke,
    input  logic [pHdisplayWidth-1:0] iHdisplay,
    input  logic [pVdisplayWidth-1:0] iVdisplay,
    input  logic [pColorDepth-1:0]    iPixel,
    input  logic                      iVd,
    output logic [pColorDepth-1:0]    oPixel,
    output logic [pHdisplayWidth-1:0] oHpos,
    output logic [pVdisplayWidth-1:0] oVpos,
    output logic                      oSof,
    output logic                      oEol,
    output logic                      oVd,
    input  logic                      iReady,
    output logic                      oFrameDone,
    output logic                      oFrameErr,
    output logic [pColorDepth-1:0]    oChecksum,
    output logic                      oOverflow,
    input  logic                      iClrErr
);

    rxState_t                  state;
    rxState_t                  stateNxt;
    logic [pHdisplayWidth-1:0] hcnt;
    logic [pHdisplayWidth-1:0] hdispQ;
    logic [pHdisplayWidth-1:0] hLastIdx;
    logic [pVdisplayWidth-1:0] vcnt;
    logic [pVdisplayWidth-1:0] vdispQ;
    logic [pVdisplayWidth-1:0] vLastIdx;
    logic [pColorDepth-1:0]    acc;
    logic [pColorDepth-1:0]    accNext;
    logic                      accept;
    logic                      frameStart;
    logic                      lastH;
    logic                      lastBeat;
    logic                      pushOk;
    logic                      push;
    logic                      drop;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic                      errFlag;
    fifoEntry_t                wrEntry;
    fifoEntry_t                rdEntry;

    assign accept     = iCke && iVd;
    assign frameStart = (hcnt == '0) && (vcnt == '0);

    // Geometry applies from the live inputs on the first beat,
    // and from the latched copy for the rest of the frame.
    assign hLastIdx = (frameStart ? iHdisplay : hdispQ)
                      - pHdisplayWidth'(1);
    assign vLastIdx = (frameStart ? iVdisplay : vdispQ)
                      - pVdisplayWidth'(1);
    assign lastH    = hcnt == hLastIdx;
    assign lastBeat = lastH && (vcnt == vLastIdx);

    assign oVd    = !empty;
    assign pop    = oVd && iReady;
    assign pushOk = !full || pop;

    assign accNext = (frameStart ? '0 : acc)
                     + (push ? iPixel : '0);

    // Pack the current beat and its raster position.
    always_comb begin
        wrEntry       = '0;
        wrEntry.pixel = cColorDepth'(iPixel);
        wrEntry.hpos  = cCoordWidth'(hcnt);
        wrEntry.vpos  = cCoordWidth'(vcnt);
        wrEntry.sof   = frameStart;
        wrEntry.eol   = lastH;
    end

    assign oPixel = rdEntry.pixel[pColorDepth-1:0];
    assign oHpos  = rdEntry.hpos[pHdisplayWidth-1:0];
    assign oVpos  = rdEntry.vpos[pVdisplayWidth-1:0];
    assign oSof   = rdEntry.sof;
    assign oEol   = rdEntry.eol;

    // Next state and push/drop decision for the current beat.
    always_comb begin
        stateNxt = state;
        push     = 1'b0;
        drop     = 1'b0;
        unique case (state)
            S_IDLE, S_ACTIVE: begin
                if (accept) begin
                    push     = pushOk;
                    drop     = !pushOk;
                    stateNxt = (!pushOk && !lastBeat)
                               ? S_DROP : S_ACTIVE;
                end
            end
            S_DROP: begin
                if (accept && lastBeat) begin
                    stateNxt = S_ACTIVE;
                end
            end
            default: stateNxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= S_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Raster counters track every accepted beat, dropped or not.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            hcnt   <= '0;
            vcnt   <= '0;
            hdispQ <= '0;
            vdispQ <= '0;
        end else if (accept) begin
            if (frameStart) begin
                hdispQ <= iHdisplay;
                vdispQ <= iVdisplay;
            end
            if (lastH) begin
                hcnt <= '0;
                vcnt <= lastBeat ? '0
                        : vcnt + pVdisplayWidth'(1);
            end else begin
                hcnt <= hcnt + pHdisplayWidth'(1);
            end
        end
    end

    // Checksum accumulation and end-of-frame reporting.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            acc        <= '0;
            oChecksum  <= '0;
            oFrameDone <= 1'b0;
            oFrameErr  <= 1'b0;
            errFlag    <= 1'b0;
        end else begin
            oFrameDone <= accept && lastBeat;
            oFrameErr  <= accept && lastBeat
                          && (errFlag || drop);
            if (accept) begin
                acc <= accNext;
                if (lastBeat) begin
                    oChecksum <= accNext;
                    errFlag   <= 1'b0;
                end else if (drop) begin
                    errFlag <= 1'b1;
                end
            end
        end
    end

    // Sticky overflow; a new drop beats a coincident clear.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            oOverflow <= 1'b0;
        end else if (drop) begin
            oOverflow <= 1'b1;
        end else if (iClrErr) begin
            oOverflow <= 1'b0;
        end
    end

    video_pixel_rx_fifo #(
        .pDepth (pFifoDepth)
    ) uFifo (
        .iClk   (iClk),
        .iRst   (iRst),
        .iPush  (push),
        .iData  (wrEntry),
        .iPop   (pop),
        .oData  (rdEntry),
        .oFull  (full),
        .oEmpty (empty)
    );

endmodule

// File: tb/tb_video_pixel_rx.sv
// Self-checking bench for video_pixel_rx: table-driven
// 4x3 frames, a large frame, overflow, stall and reset cases.
module tb_video_pixel_rx;
    import video_rx_pkg::*;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iCke;
    logic [10:0] iHdisplay;
    logic [10:0] iVdisplay;
    logic [15:0] iPixel;
    logic        iVd;
    logic [15:0] oPixel;
    logic [10:0] oHpos;
    logic [10:0] oVpos;
    logic        oSof;
    logic        oEol;
    logic        oVd;
    logic        iReady;
    logic        oFrameDone;
    logic        oFrameErr;
    logic [15:0] oChecksum;
    logic        oOverflow;
    logic        iClrErr;

    video_pixel_rx #(
        .pHdisplayWidth (11),
        .pVdisplayWidth (11),
        .pColorDepth    (16),
        .pFifoDepth     (4)
    ) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iCke       (iCke),
        .iHdisplay  (iHdisplay),
        .iVdisplay  (iVdisplay),
        .iPixel     (iPixel),
        .iVd        (iVd),
        .oPixel     (oPixel),
        .oHpos      (oHpos),
        .oVpos      (oVpos),
        .oSof       (oSof),
        .oEol       (oEol),
        .oVd        (oVd),
        .iReady     (iReady),
        .oFrameDone (oFrameDone),
        .oFrameErr  (oFrameErr),
        .oChecksum  (oChecksum),
        .oOverflow  (oOverflow),
        .iClrErr    (iClrErr)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [15:0] pix;
        logic [10:0] h;
        logic [10:0] v;
        logic        sof;
        logic        eol;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        err;
    } frm_t;

    vec_t tbl [12];
    vec_t sb [$];
    frm_t fq [$];
    vec_t held;
    logic stallPrev = 1'b0;
    int   nChecks = 0;
    int   nErrors = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nErrors++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, req);
        end
    endtask

    task automatic monitor();
        vec_t e;
        frm_t f;
        if (stallPrev) begin
            check("stall_hold",
                  {oPixel, oHpos, oVpos, oSof, oEol},
                  {held.pix, held.h, held.v, held.sof, held.eol});
        end
        stallPrev = oVd && !iReady;
        held = '{oPixel, oHpos, oVpos, oSof, oEol};
        if (oVd && iReady) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("pixel", oPixel, e.pix);
                check("hpos", oHpos, e.h);
                check("vpos", oVpos, e.v);
                check("sof", oSof, e.sof);
                check("eol", oEol, e.eol);
            end
        end
        if (oFrameDone) begin
            if (fq.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                f = fq.pop_front();
                check("checksum", oChecksum, f.sum);
                check("frame_err", oFrameErr, f.err);
            end
        end
    endtask

    task automatic step();
        @(negedge iClk);
        monitor();
        @(posedge iClk);
        #1;
    endtask

    task automatic beat(input logic [15:0] pix,
                        input logic vd);
        iPixel = pix;
        iVd = vd;
        step();
    endtask

    task automatic drain();
        int k = 0;
        iVd = 1'b0;
        while ((sb.size() != 0 || fq.size() != 0) && k < 500) begin
            step();
            k++;
        end
        check("drain", 64'(sb.size() + fq.size()), 64'd0);
    endtask

    // mode 0: plain, 1: paced + toggling ready + iCke gaps,
    // 2: ready held low (overflow), 3: geometry changed mid-frame
    task automatic runTable(input int mode);
        iHdisplay = 11'd4;
        iVdisplay = 11'd3;
        for (int i = 0; i < 12; i++) begin
            if (mode == 1) begin
                iReady = ~iReady;
                iCke = 1'b0;
                beat(16'hDEAD, 1'b1);
                iCke = 1'b1;
                iReady = ~iReady;
            end
            if (mode == 3) begin
                iHdisplay = (i >= 2 && i < 11) ? 11'd5 : 11'd4;
                iVdisplay = (i >= 2 && i < 11) ? 11'd2 : 11'd3;
            end
            iClrErr = (mode == 2 && i == 4);
            if (mode != 2 || i < 4) begin
                sb.push_back(tbl[i]);
            end
            beat(tbl[i].pix, 1'b1);
            if (mode == 2 && i == 4) begin
                check("ovf_set_wins", oOverflow, 1'b1);
                check("state_drop", 64'(dut.state), 64'(S_DROP));
            end
        end
        iClrErr = 1'b0;
        iVd = 1'b0;
        if (mode == 2) begin
            fq.push_back('{16'h0006, 1'b1});
        end else begin
            fq.push_back('{16'h0042, 1'b0});
        end
    endtask

    task automatic runFrame(input int w, input int h,
                            input logic [15:0] base,
                            input logic [15:0] expSum);
        iHdisplay = 11'(w);
        iVdisplay = 11'(h);
        for (int i = 0; i < w * h; i++) begin
            vec_t e;
            e.pix = base + 16'(i);
            e.h = 11'(i % w);
            e.v = 11'(i / w);
            e.sof = (i == 0);
            e.eol = ((i % w) == (w - 1));
            sb.push_back(e);
            beat(e.pix, 1'b1);
        end
        iVd = 1'b0;
        fq.push_back('{expSum, 1'b0});
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin
            tbl[i].pix = 16'(i);
            tbl[i].h = 11'(i % 4);
            tbl[i].v = 11'(i / 4);
            tbl[i].sof = (i == 0);
            tbl[i].eol = ((i % 4) == 3);
        end

        iRst = 1'b0;
        iCke = 1'b1;
        iVd = 1'b0;
        iPixel = '0;
        iReady = 1'b1;
        iClrErr = 1'b0;
        iHdisplay = 11'd4;
        iVdisplay = 11'd3;
        #1;
        check("reset_outs",
              {oVd, oPixel, oHpos, oVpos, oSof, oEol,
               oFrameDone, oFrameErr, oChecksum, oOverflow},
              64'd0);
        check("reset_state", 64'(dut.state), 64'(S_IDLE));
        step();
        step();
        iRst = 1'b1;
        step();
        check("idle_no_vd", oVd, 1'b0);

        runTable(3);
        runTable(0);
        drain();

        runTable(1);
        drain();

        runFrame(1, 1, 16'h1234, 16'h1234);
        runFrame(1, 1, 16'hABCD, 16'hABCD);
        drain();

        runFrame(120, 272, 16'h0000, 16'hE040);
        drain();

        iReady = 1'b0;
        runTable(2);
        step();
        step();
        check("ovf_done_seen", 64'(fq.size()), 64'd0);
        check("ovf_sticky", oOverflow, 1'b1);
        iReady = 1'b1;
        runTable(0);
        drain();
        check("ovf_still_set", oOverflow, 1'b1);
        iClrErr = 1'b1;
        step();
        iClrErr = 1'b0;
        check("ovf_cleared", oOverflow, 1'b0);

        for (int i = 0; i < 6; i++) begin
            sb.push_back(tbl[i]);
            beat(tbl[i].pix, 1'b1);
        end
        iVd = 1'b0;
        iRst = 1'b0;
        #1;
        check("midframe_rst_outs",
              {oVd, oPixel, oHpos, oVpos, oSof, oEol,
               oFrameDone, oFrameErr, oChecksum, oOverflow},
              64'd0);
        check("midframe_rst_state", 64'(dut.state), 64'(S_IDLE));
        sb.delete();
        stallPrev = 1'b0;
        step();
        step();
        iRst = 1'b1;
        step();
        runTable(0);
        drain();

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
